// File: rtl/reset_pkg.sv
// Shared types and default timing constants for the reset/halt sequencer.
package reset_pkg;

  // Cause of the most recent reset, reported on CAUSE and held until the next hold.
  typedef enum logic [1:0] {
    POR      = 2'd0,
    BTN      = 2'd1,
    WDT      = 2'd2,
    DBLFAULT = 2'd3
  } cause_t;

  // Sequencer states. Both *_HOLD states assert RESET, HALT and PERIPH_RESET.
  typedef enum logic [1:0] {
    POR_HOLD    = 2'd0,
    WARM_HOLD   = 2'd1,
    RUN_ST      = 2'd2,
    PERIPH_ONLY = 2'd3
  } state_t;

  // Default cycle counts at a 1 MHz MCLK_IN.
  localparam int DEF_POR_CYCLES      = 100000;
  localparam int DEF_HOLD_CYCLES     = 1000;
  localparam int DEF_DEBOUNCE_CYCLES = 5000;
  localparam int DEF_WDT_CYCLES      = 1000000;
  localparam int DEF_CNT_W           = 20;

  // True in the states that hold the CPU in reset.
  function automatic logic is_hold(input state_t s);
    return (s == POR_HOLD) || (s == WARM_HOLD);
  endfunction

  // Fixed priority among simultaneous warm-reset sources: button, then watchdog,
  // then double fault (the caller only asks when at least one is active).
  function automatic cause_t warm_cause(input logic btn, input logic wdt);
    if (btn) return BTN;
    if (wdt) return WDT;
    return DBLFAULT;
  endfunction

endpackage

// File: rtl/reset_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-level filter and a
// one-cycle press pulse when the filtered level falls.
module reset_debounce
  import reset_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic MCLK_IN,
  input  logic RST_IN,
  input  logic BTN_N,
  output logic PRESS
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  // sync_q[1] is the metastability-safe copy of BTN_N.
  logic [1:0]    sync_q;
  logic          level_q;
  logic [DW-1:0] cnt_q;

  // Synchronise BTN_N, then accept a new level only after it has differed from
  // the filtered level for DEBOUNCE_CYCLES consecutive cycles. Only the
  // released-to-pressed transition produces a pulse, so holding never retriggers.
  always_ff @(posedge MCLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      PRESS   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], BTN_N};
      PRESS  <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEB_LAST) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        PRESS   <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Central reset/halt controller for the 68000 system. Combines power-on,
// push-button, watchdog, double-bus-fault and CPU RESET-instruction sources into
// registered RESET/HALT/PERIPH_RESET/RUN outputs and a sticky cause code.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int POR_CYCLES      = DEF_POR_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int WDT_CYCLES      = DEF_WDT_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       MCLK_IN,
  input  logic       RST_IN,
  input  logic       BTN_N,
  input  logic       WDT_EN,
  input  logic       WDT_KICK,
  input  logic       CPU_RSTO,
  input  logic       CPU_HALTED,
  output logic       RESET,
  output logic       HALT,
  output logic       PERIPH_RESET,
  output logic       RUN,
  output logic [1:0] CAUSE,
  output state_t     STATE_DBG
);

  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WDT_LAST  = CNT_W'(WDT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wdt_q, wdt_d;
  cause_t           cause_q, cause_d;
  logic             halted_q;
  logic             btn_evt;
  logic             wdt_timeout;
  logic             dbl_evt;
  logic             warm_req;

  reset_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .MCLK_IN(MCLK_IN),
    .RST_IN (RST_IN),
    .BTN_N  (BTN_N),
    .PRESS  (btn_evt)
  );

  // Warm-reset sources. Watchdog and double fault are only live in RUN_ST; a
  // kick in the timeout cycle suppresses the timeout.
  always_comb begin
    wdt_timeout = (state_q == RUN_ST) && WDT_EN && !WDT_KICK && (wdt_q == WDT_LAST);
    dbl_evt     = (state_q == RUN_ST) && CPU_HALTED && !halted_q;
    warm_req    = btn_evt || wdt_timeout || dbl_evt;
  end

  // Watchdog count: advances only in RUN_ST, freezes in PERIPH_ONLY, cleared by
  // holds, kicks, disable and its own timeout.
  always_comb begin
    wdt_d = wdt_q;
    if (is_hold(state_q) || !WDT_EN || WDT_KICK || wdt_timeout) begin
      wdt_d = '0;
    end else if (state_q == RUN_ST) begin
      wdt_d = wdt_q + 1'b1;
    end
  end

  // Next state, hold counter and cause. Cause only changes on entry to (or a
  // button restart of) a hold, so it stays sticky through RUN_ST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    cause_d = cause_q;
    case (state_q)
      POR_HOLD: begin
        if (cnt_q == POR_LAST) begin
          state_d = RUN_ST;
          cnt_d   = '0;
        end
      end
      WARM_HOLD: begin
        if (btn_evt) begin
          cnt_d   = '0;
          cause_d = BTN;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN_ST;
          cnt_d   = '0;
        end
      end
      RUN_ST: begin
        cnt_d = '0;
        if (warm_req) begin
          state_d = WARM_HOLD;
          cause_d = warm_cause(btn_evt, wdt_timeout);
        end else if (CPU_RSTO) begin
          state_d = PERIPH_ONLY;
        end
      end
      PERIPH_ONLY: begin
        cnt_d = '0;
        if (warm_req) begin
          state_d = WARM_HOLD;
          cause_d = warm_cause(btn_evt, wdt_timeout);
        end else if (!CPU_RSTO) begin
          state_d = RUN_ST;
        end
      end
      default: begin
        state_d = POR_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // State, hold counter and cause registers.
  always_ff @(posedge MCLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q <= POR_HOLD;
      cnt_q   <= '0;
      cause_q <= POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Watchdog counter and the CPU_HALTED edge-detect history.
  always_ff @(posedge MCLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      wdt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      wdt_q    <= wdt_d;
      halted_q <= CPU_HALTED;
    end
  end

  // Outputs are decoded from the next state and registered, so they change in
  // step with the state register and are glitch-free at the pins.
  always_ff @(posedge MCLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      RESET        <= 1'b1;
      HALT         <= 1'b1;
      PERIPH_RESET <= 1'b1;
      RUN          <= 1'b0;
    end else begin
      RESET        <= is_hold(state_d);
      HALT         <= is_hold(state_d);
      PERIPH_RESET <= is_hold(state_d) || (state_d == PERIPH_ONLY);
      RUN          <= !is_hold(state_d);
    end
  end

  assign CAUSE     = cause_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios with randomised lengths plus a
// random soak, every cycle compared against a behavioural model.
module tb_reset_sequencer;
  import reset_pkg::*;

  localparam int POR_N  = 20;
  localparam int HOLD_N = 8;
  localparam int DEB_N  = 4;
  localparam int WDT_N  = 50;

  // ---------------- clock / reset / DUT ----------------
  logic       MCLK_IN    = 1'b0;
  logic       RST_IN     = 1'b1;
  logic       BTN_N      = 1'b1;
  logic       WDT_EN     = 1'b0;
  logic       WDT_KICK   = 1'b0;
  logic       CPU_RSTO   = 1'b0;
  logic       CPU_HALTED = 1'b0;
  logic       RESET, HALT, PERIPH_RESET, RUN;
  logic [1:0] CAUSE;
  state_t     STATE_DBG;

  always #5 MCLK_IN = ~MCLK_IN;

  reset_sequencer #(
    .POR_CYCLES     (POR_N),
    .HOLD_CYCLES    (HOLD_N),
    .DEBOUNCE_CYCLES(DEB_N),
    .WDT_CYCLES     (WDT_N),
    .CNT_W          (20)
  ) dut (
    .MCLK_IN     (MCLK_IN),
    .RST_IN      (RST_IN),
    .BTN_N       (BTN_N),
    .WDT_EN      (WDT_EN),
    .WDT_KICK    (WDT_KICK),
    .CPU_RSTO    (CPU_RSTO),
    .CPU_HALTED  (CPU_HALTED),
    .RESET       (RESET),
    .HALT        (HALT),
    .PERIPH_RESET(PERIPH_RESET),
    .RUN         (RUN),
    .CAUSE       (CAUSE),
    .STATE_DBG   (STATE_DBG)
  );

  // ---------------- scoreboard ----------------
  logic [5:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_cycles = 0;
  int periph_cycles = 0;

  // ---------------- reference model ----------------
  // hold_left: cycles of RESET still to come (0 = CPU running)
  int m_hold_left;
  bit m_hold_por;
  bit m_periph;
  int m_wdt;
  int m_cause;
  bit m_halted_prev;
  bit m_sync[$];
  bit m_level;
  bit m_last;
  int m_stable;
  bit m_press;

  task automatic model_reset();
    m_hold_left   = POR_N;
    m_hold_por    = 1'b1;
    m_periph      = 1'b0;
    m_wdt         = 0;
    m_cause       = 0;
    m_halted_prev = 1'b0;
    m_sync.delete();
    m_sync.push_back(1'b1);
    m_sync.push_back(1'b1);
    m_level  = 1'b1;
    m_last   = 1'b1;
    m_stable = DEB_N + 1;
    m_press  = 1'b0;
  endtask

  function automatic logic [5:0] model_exp();
    bit hold;
    hold = (m_hold_left > 0);
    return {hold, hold, hold || m_periph, !hold, 2'(m_cause)};
  endfunction

  // Advance the model across one rising edge using the inputs as they stand.
  task automatic model_edge();
    bit btn_evt, running, tmo, dbl, s2;
    btn_evt = m_press;
    running = (m_hold_left == 0) && !m_periph;
    tmo     = running && WDT_EN && !WDT_KICK && (m_wdt == WDT_N - 1);
    dbl     = running && CPU_HALTED && !m_halted_prev;
    // button: two-sample delay, then the level must sit still DEB_N samples
    s2 = m_sync.pop_front();
    m_sync.push_back(BTN_N);
    if (s2 == m_last) begin
      if (m_stable <= DEB_N) m_stable++;
    end else begin
      m_last   = s2;
      m_stable = 1;
    end
    m_press = 1'b0;
    if (m_stable == DEB_N && s2 != m_level) begin
      m_level = s2;
      m_press = !s2;
    end
    // sequencing
    if (m_hold_left > 0) begin
      m_wdt    = 0;
      m_periph = 1'b0;
      if (btn_evt && !m_hold_por) begin
        m_hold_left = HOLD_N;
        m_cause     = 1;
      end else begin
        m_hold_left--;
      end
    end else begin
      if (!WDT_EN || WDT_KICK || tmo) m_wdt = 0;
      else if (!m_periph) m_wdt++;
      if (btn_evt || tmo || dbl) begin
        m_hold_left = HOLD_N;
        m_hold_por  = 1'b0;
        m_periph    = 1'b0;
        m_cause     = btn_evt ? 1 : (tmo ? 2 : 3);
      end else begin
        m_periph = CPU_RSTO;
      end
    end
    m_halted_prev = CPU_HALTED;
  endtask

  // ---------------- check / driver tasks ----------------
  task automatic compare_outputs(input string tag);
    logic [5:0] got, exp;
    got = {RESET, HALT, PERIPH_RESET, RUN, CAUSE};
    exp = exp_q.pop_front();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got {RST,HLT,PRST,RUN,CAUSE}=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    model_edge();
    exp_q.push_back(model_exp());
    @(posedge MCLK_IN);
    #1;
    cyc++;
    if (RESET === 1'b1) rst_cycles++;
    if (PERIPH_RESET === 1'b1) periph_cycles++;
    compare_outputs("cycle");
  endtask

  // Tick until RESET is seen, bounded; returns the number of ticks taken.
  task automatic wait_reset(input int max_cycles, output int n);
    n = 0;
    while (RESET !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
  endtask

  // Count consecutive cycles with RESET high, starting from the current one.
  task automatic hold_len(input int max_cycles, output int n);
    n = 0;
    while (RESET === 1'b1 && n < max_cycles) begin
      n++;
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, r0, p0, len, period;

    // 1. power-on
    model_reset();
    repeat (3) @(posedge MCLK_IN);
    #1;
    exp_q.push_back(model_exp());
    compare_outputs("in_reset");
    check_int("in_reset_state", int'(STATE_DBG), int'(POR_HOLD));
    RST_IN = 1'b0;
    hold_len(100, n);
    check_int("por_len", n, POR_N);
    check_int("por_run", int'(RUN), 1);
    check_int("por_cause", int'(CAUSE), 0);
    repeat ($urandom_range(3, 10)) tick();

    // 2. button glitch, then a real press held past the hold
    r0 = rst_cycles;
    BTN_N = 1'b0;
    repeat (DEB_N - 1) tick();
    BTN_N = 1'b1;
    repeat (15) tick();
    check_int("glitch_no_reset", rst_cycles - r0, 0);
    r0 = rst_cycles;
    BTN_N = 1'b0;
    len = $urandom_range(10, 30);
    repeat (len) tick();
    BTN_N = 1'b1;
    repeat (20) tick();
    check_int("btn_hold_cycles", rst_cycles - r0, HOLD_N);
    check_int("btn_cause", int'(CAUSE), 1);

    // 3. watchdog timeout, then regular kicks
    WDT_EN = 1'b1;
    wait_reset(WDT_N + 20, n);
    check_int("wdt_latency", n, WDT_N);
    hold_len(40, n);
    check_int("wdt_hold_len", n, HOLD_N);
    check_int("wdt_cause", int'(CAUSE), 2);
    r0 = rst_cycles;
    period = $urandom_range(20, 40);
    for (int t = 0; t < 500; t += period) begin
      WDT_KICK = 1'b1;
      tick();
      WDT_KICK = 1'b0;
      repeat (period - 1) tick();
    end
    check_int("wdt_kicked_no_reset", rst_cycles - r0, 0);
    WDT_EN = 1'b0;
    repeat (5) tick();

    // 4. CPU RESET instruction: peripherals only
    r0 = rst_cycles;
    p0 = periph_cycles;
    CPU_RSTO = 1'b1;
    repeat (124) tick();
    CPU_RSTO = 1'b0;
    repeat (6) tick();
    check_int("periph_len", periph_cycles - p0, 124);
    check_int("periph_no_cpu_reset", rst_cycles - r0, 0);

    // 5a. double fault coincident with a debounced press: button wins
    BTN_N = 1'b0;
    n = 0;
    while (!m_press && n < 20) begin
      tick();
      n++;
    end
    check_int("press_arrived", int'(m_press), 1);
    r0 = rst_cycles;
    CPU_HALTED = 1'b1;
    repeat (20) tick();
    BTN_N = 1'b1;
    CPU_HALTED = 1'b0;
    repeat (12) tick();
    check_int("dual_hold_cycles", rst_cycles - r0, HOLD_N);
    check_int("dual_cause", int'(CAUSE), 1);

    // 5b. double-fault hold restarted by a press landing in hold cycle 5
    BTN_N = 1'b0;
    tick();
    r0 = rst_cycles;
    CPU_HALTED = 1'b1;
    tick();
    check_int("dbl_cause", int'(CAUSE), 3);
    repeat (20) tick();
    check_int("restart_hold_cycles", rst_cycles - r0, 13);
    check_int("restart_cause", int'(CAUSE), 1);
    BTN_N = 1'b1;
    CPU_HALTED = 1'b0;
    repeat (12) tick();

    // 6. RST_IN during a warm hold
    BTN_N = 1'b0;
    wait_reset(20, n);
    check_int("warm_seen", int'(RESET), 1);
    repeat (2) tick();
    #2;
    RST_IN = 1'b1;
    model_reset();
    exp_q.push_back(model_exp());
    #1;
    compare_outputs("async_rst");
    check_int("async_rst_state", int'(STATE_DBG), int'(POR_HOLD));
    BTN_N = 1'b1;
    repeat (2) @(posedge MCLK_IN);
    #1;
    exp_q.push_back(model_exp());
    compare_outputs("rst_held");
    RST_IN = 1'b0;
    hold_len(100, n);
    check_int("por2_len", n, POR_N);
    check_int("por2_cause", int'(CAUSE), 0);

    // 7. random soak
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) BTN_N = ~BTN_N;
      if ($urandom_range(0, 31) == 0) CPU_RSTO = ~CPU_RSTO;
      if ($urandom_range(0, 39) == 0) CPU_HALTED = ~CPU_HALTED;
      if ($urandom_range(0, 99) == 0) WDT_EN = ~WDT_EN;
      WDT_KICK = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
